// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - requester and memory bus bundle for the memory arbiter
interface mem_arb_if #(
    parameter int N_REQ = 4,
    parameter int AW    = 64,
    parameter int DW    = 64
);
    logic [N_REQ-1:0]    r_req;
    logic [N_REQ-1:0]    r_wr;
    logic [N_REQ*AW-1:0] r_addr;
    logic [N_REQ*DW-1:0] r_wdata;
    logic [N_REQ-1:0]    r_rdy;
    logic [DW-1:0]       r_rdata;
    logic                m_req;
    logic                m_wr;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_dout;
    logic [DW-1:0]       m_din;
    logic                m_rdy;

    modport slave (
        input  r_req, r_wr, r_addr, r_wdata, m_din, m_rdy,
        output r_rdy, r_rdata, m_req, m_wr, m_addr, m_dout
    );

    modport master (
        output r_req, r_wr, r_addr, r_wdata, m_din, m_rdy,
        input  r_rdy, r_rdata, m_req, m_wr, m_addr, m_dout
    );
endinterface

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - round-robin N:1 memory arbiter with transaction watchdog
module mem_arb #(
    parameter int N_REQ = 4,
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int TMO   = 256
) (
    input  logic        clk,
    input  logic        rst,
    mem_arb_if.slave    bus,
    output logic [31:0] txn_cnt,
    output logic        err
);
    localparam int IW = $clog2(N_REQ);
    localparam int WW = $clog2(TMO);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             m_req_q, m_req_d;
    logic             m_wr_q, m_wr_d;
    logic [AW-1:0]    m_addr_q, m_addr_d;
    logic [DW-1:0]    m_dout_q, m_dout_d;
    logic [DW-1:0]    r_rdata_q, r_rdata_d;
    logic [N_REQ-1:0] r_rdy_q, r_rdy_d;
    logic [31:0]      txn_cnt_q, txn_cnt_d;
    logic             err_q, err_d;

    logic             grant_ok;
    logic [IW-1:0]    grant_idx;
    int               cand;

    // Circular search starting at ptr; the first hit wins.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr_q) + k) % N_REQ;
            if (!grant_ok && bus.r_req[cand]) begin
                grant_ok  = 1'b1;
                grant_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        m_req_d   = m_req_q;
        m_wr_d    = m_wr_q;
        m_addr_d  = m_addr_q;
        m_dout_d  = m_dout_q;
        r_rdata_d = r_rdata_q;
        r_rdy_d   = r_rdy_q;
        txn_cnt_d = txn_cnt_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    state_d  = BUSY;
                    idx_d    = grant_idx;
                    wd_d     = '0;
                    m_req_d  = 1'b1;
                    m_wr_d   = bus.r_wr[grant_idx];
                    m_addr_d = bus.r_addr[int'(grant_idx)*AW +: AW];
                    m_dout_d = bus.r_wdata[int'(grant_idx)*DW +: DW];
                end
            end
            BUSY: begin
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (bus.m_rdy) begin
                    state_d   = DONE;
                    m_req_d   = 1'b0;
                    r_rdata_d = bus.m_din;
                    r_rdy_d   = N_REQ'(1) << idx_q;
                end else if (wd_q == WW'(TMO - 1)) begin
                    state_d   = DONE;
                    m_req_d   = 1'b0;
                    r_rdata_d = '0;
                    err_d     = 1'b1;
                    r_rdy_d   = N_REQ'(1) << idx_q;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                r_rdy_d   = '0;
                txn_cnt_d = txn_cnt_q + 32'd1;
                ptr_d     = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            wd_q      <= '0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_dout_q  <= '0;
            r_rdata_q <= '0;
            r_rdy_q   <= '0;
            txn_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_dout_q  <= m_dout_d;
            r_rdata_q <= r_rdata_d;
            r_rdy_q   <= r_rdy_d;
            txn_cnt_q <= txn_cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_wr    = m_wr_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_dout  = m_dout_q;
    assign bus.r_rdy   = r_rdy_q;
    assign bus.r_rdata = r_rdata_q;
    assign txn_cnt     = txn_cnt_q;
    assign err         = err_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb
module tb_mem_arb;
    localparam int N   = 4;
    localparam int TMO = 256;

    typedef struct {
        int          idx;
        logic [63:0] rdata;
        logic        err;
        int          len;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] dout;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] txn_cnt;
    logic        err;

    mem_arb_if #(.N_REQ(N), .AW(64), .DW(64)) bus_i ();

    mem_arb #(.N_REQ(N), .AW(64), .DW(64), .TMO(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_i),
        .txn_cnt (txn_cnt),
        .err     (err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    cmd_t        cmd_q[$];
    logic [63:0] dat_q[$];
    int          mem_lat   = 0;
    logic        force_rdy = 1'b0;
    int          bcnt      = 0;
    int          last_len  = 0;
    int          pulses[N];
    cmd_t        cur;
    exp_t        e;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    // Memory responder and completion monitor share one process to keep ordering fixed.
    initial begin : bfm
        for (int i = 0; i < N; i++) pulses[i] = 0;
        bus_i.m_rdy = 1'b0;
        bus_i.m_din = '0;
        forever begin
            @(negedge clk);
            if (bus_i.m_req) begin
                bcnt++;
                if (bcnt == 1) begin
                    if (cmd_q.size() == 0) chk("m_req_unexp", 128'(bus_i.m_req), 128'(0));
                    else begin
                        cur = cmd_q.pop_front();
                        chk("m_wr", 128'(bus_i.m_wr), 128'(cur.wr));
                        chk("m_addr", 128'(bus_i.m_addr), 128'(cur.addr));
                        chk("m_dout", 128'(bus_i.m_dout), 128'(cur.dout));
                    end
                end else if (bcnt == mem_lat || bcnt == TMO) begin
                    chk("m_addr_hold", 128'(bus_i.m_addr), 128'(cur.addr));
                    chk("m_dout_hold", 128'(bus_i.m_dout), 128'(cur.dout));
                end
                if (mem_lat > 0 && bcnt == mem_lat) begin
                    bus_i.m_rdy = 1'b1;
                    bus_i.m_din = (dat_q.size() > 0) ? dat_q.pop_front() : 64'h0;
                end else begin
                    bus_i.m_rdy = force_rdy;
                end
            end else begin
                if (bcnt > 0) last_len = bcnt;
                bcnt = 0;
                bus_i.m_rdy = force_rdy;
            end
            if (bus_i.r_rdy != '0) begin
                if (exp_q.size() == 0) chk("rdy_unexp", 128'(bus_i.r_rdy), 128'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("rdy_idx", 128'(bus_i.r_rdy), 128'(1) << e.idx);
                    chk("r_rdata", 128'(bus_i.r_rdata), 128'(e.rdata));
                    chk("err_at_rdy", 128'(err), 128'(e.err));
                    if (e.len > 0) chk("busy_len", 128'(last_len), 128'(e.len));
                end
                for (int i = 0; i < N; i++) if (bus_i.r_rdy[i]) pulses[i]++;
            end
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [63:0] addr, input logic [63:0] wd);
        bus_i.r_wr[i]            = wr;
        bus_i.r_addr[i*64 +: 64]  = addr;
        bus_i.r_wdata[i*64 +: 64] = wd;
    endtask

    task automatic push_txn(input int i, input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                            input logic [63:0] din, input logic exp_rd_zero, input logic exp_err, input int len);
        cmd_q.push_back('{wr: wr, addr: addr, dout: wd});
        if (!exp_rd_zero) dat_q.push_back(din);
        exp_q.push_back('{idx: i, rdata: exp_rd_zero ? 64'h0 : din, err: exp_err, len: len});
    endtask

    // Waits for n completion pulses; requesters in drop release r_req when served.
    task automatic run(input int n, input logic [N-1:0] drop, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
            if (bus_i.r_rdy != '0) begin
                got++;
                bus_i.r_req = bus_i.r_req & ~(bus_i.r_rdy & drop);
            end
        end
        chk("rdy_budget", 128'(got), 128'(n));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    int snap[N];

    initial begin
        bus_i.r_req   = '0;
        bus_i.r_wr    = '0;
        bus_i.r_addr  = '0;
        bus_i.r_wdata = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_m_req", 128'(bus_i.m_req), 128'(0));
        chk("rst_m_wr", 128'(bus_i.m_wr), 128'(0));
        chk("rst_m_addr", 128'(bus_i.m_addr), 128'(0));
        chk("rst_m_dout", 128'(bus_i.m_dout), 128'(0));
        chk("rst_r_rdy", 128'(bus_i.r_rdy), 128'(0));
        chk("rst_r_rdata", 128'(bus_i.r_rdata), 128'(0));
        chk("rst_txn_cnt", 128'(txn_cnt), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        @(negedge clk);
        #1 rst = 1'b0;

        // Single read
        set_req(2, 1'b0, 64'h1FFF, 64'h0);
        push_txn(2, 1'b0, 64'h1FFF, 64'h0, 64'hDEADBEEF_00000001, 1'b0, 1'b0, 3);
        mem_lat = 3;
        bus_i.r_req = 4'b0100;
        run(1, 4'b0100, 50);
        @(negedge clk); #1;
        chk("txn_single", 128'(txn_cnt), 128'(1));

        // Read-modify-write on requester 1
        snap[1] = pulses[1];
        set_req(1, 1'b0, 64'h10, 64'h0);
        push_txn(1, 1'b0, 64'h10, 64'h0, 64'h5, 1'b0, 1'b0, 1);
        mem_lat = 1;
        bus_i.r_req = 4'b0010;
        run(1, 4'b0010, 50);
        set_req(1, 1'b1, 64'h10, 64'h6);
        push_txn(1, 1'b1, 64'h10, 64'h6, 64'hA5, 1'b0, 1'b0, 2);
        mem_lat = 2;
        bus_i.r_req = 4'b0010;
        run(1, 4'b0010, 50);
        @(negedge clk); #1;
        chk("txn_rmw", 128'(txn_cnt), 128'(3));
        chk("rmw_pulses", 128'(pulses[1] - snap[1]), 128'(2));

        // Fairness with every requester held high
        apply_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 64'h100 * (i + 1), 64'h0);
            snap[i] = pulses[i];
        end
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < N; i++)
                push_txn(i, 1'b0, 64'h100 * (i + 1), 64'h0, 64'hF000 + 64'(rep * 4 + i), 1'b0, 1'b0, 2);
        mem_lat = 2;
        bus_i.r_req = 4'hF;
        run(8, 4'h0, 200);
        bus_i.r_req = '0;
        for (int i = 0; i < N; i++) chk("fair_pulses", 128'(pulses[i] - snap[i]), 128'(2));
        @(negedge clk); #1;
        chk("txn_fair", 128'(txn_cnt), 128'(8));

        // Reset two cycles into BUSY, then a stray m_rdy
        set_req(0, 1'b0, 64'h40, 64'h0);
        cmd_q.push_back('{wr: 1'b0, addr: 64'h40, dout: 64'h0});
        mem_lat = 0;
        bus_i.r_req = 4'b0001;
        for (int c = 0; c < 10 && !bus_i.m_req; c++) begin
            @(negedge clk); #1;
        end
        chk("mid_busy_entered", 128'(bus_i.m_req), 128'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        bus_i.r_req = '0;
        #1;
        chk("mid_rst_m_req", 128'(bus_i.m_req), 128'(0));
        chk("mid_rst_txn", 128'(txn_cnt), 128'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        force_rdy = 1'b1;
        @(negedge clk);
        #1 force_rdy = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("late_rdy_m_req", 128'(bus_i.m_req), 128'(0));
        chk("late_rdy_txn", 128'(txn_cnt), 128'(0));

        // First grant after reset starts at requester 0
        set_req(1, 1'b0, 64'h111, 64'h0);
        set_req(3, 1'b1, 64'h333, 64'h99);
        push_txn(1, 1'b0, 64'h111, 64'h0, 64'h1111, 1'b0, 1'b0, 1);
        push_txn(3, 1'b1, 64'h333, 64'h99, 64'h3333, 1'b0, 1'b0, 1);
        mem_lat = 1;
        bus_i.r_req = 4'b1010;
        run(2, 4'b1010, 50);

        // m_rdy coinciding with watchdog expiry
        set_req(2, 1'b0, 64'h200, 64'h0);
        push_txn(2, 1'b0, 64'h200, 64'h0, 64'hC0111DE, 1'b0, 1'b0, TMO);
        mem_lat = TMO;
        bus_i.r_req = 4'b0100;
        run(1, 4'b0100, 400);
        chk("collision_err", 128'(err), 128'(0));

        // Watchdog timeout, then a normal grant
        set_req(0, 1'b0, 64'h300, 64'h0);
        push_txn(0, 1'b0, 64'h300, 64'h0, 64'h0, 1'b1, 1'b1, TMO);
        mem_lat = 0;
        bus_i.r_req = 4'b0001;
        run(1, 4'b0001, 400);
        chk("tmo_err", 128'(err), 128'(1));
        set_req(3, 1'b0, 64'h400, 64'h0);
        push_txn(3, 1'b0, 64'h400, 64'h0, 64'h77, 1'b0, 1'b1, 1);
        mem_lat = 1;
        bus_i.r_req = 4'b1000;
        run(1, 4'b1000, 50);
        @(negedge clk); #1;
        chk("err_sticky", 128'(err), 128'(1));
        chk("txn_final", 128'(txn_cnt), 128'(5));
        chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
        chk("cmd_q_empty", 128'(cmd_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
